// File: rtl/master_control_path.sv
// Layer-serial sequencing FSM for the CORDIC NN engine: loads biases/weights, runs MAC, bias-add,
// activation and output write per layer. Optional MCP_AUTO_RESTART_EN makes DONE a one-cycle pulse.
module master_control_path #(
  parameter int N_INPUTS   = 4,
  parameter int MAC_CYCLES = 16,
  parameter int AF_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] no_layers,
  input  logic [5:0] nl1,
  input  logic [5:0] nl2,
  input  logic [5:0] nl3,
  input  logic [5:0] nl4,
  input  logic [5:0] nl5,
  output logic       weight_en,
  output logic       bias_en,
  output logic       compute_en,
  output logic       af_en,
  output logic       out_shft_en,
  output logic       out_wr_en,
  output logic       output_sig,
  output logic       bias_sign,
  output logic       tot_complete,
  output logic [5:0] n,
  output logic [5:0] i
);

  localparam int CMAX0 = (MAC_CYCLES > AF_CYCLES) ? MAC_CYCLES : AF_CYCLES;
  localparam int CMAX1 = (CMAX0 > N_INPUTS) ? CMAX0 : N_INPUTS;
  localparam int CLIM  = (CMAX1 > 64) ? CMAX1 : 64;
  localparam int CW    = $clog2(CLIM + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_B, S_LOAD_W, S_MAC, S_NEXT, S_ADD_B, S_ACT, S_WR, S_DONE
  } state_t;

  typedef struct packed {
    logic       weight_en;
    logic       bias_en;
    logic       compute_en;
    logic       af_en;
    logic       out_shft_en;
    logic       out_wr_en;
    logic       output_sig;
    logic       bias_sign;
    logic       tot_complete;
    logic [5:0] n;
    logic [5:0] i;
  } ctrl_t;

  state_t        state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [5:0]    n_q, n_d;
  logic [5:0]    i_q, i_d;

  logic [5:0]    layers_eff;
  logic [5:0]    nl_raw, prev_raw;
  logic [CW-1:0] nl_cur, fan_in, phase_len;
  logic          phase_last, i_last;
  ctrl_t         ctrl_d;

  // Effective configuration for the current layer; zero neuron counts behave as one.
  always_comb begin
    layers_eff = (no_layers > 6'd5) ? 6'd5 : no_layers;
    case (n_q)
      6'd0:    nl_raw = nl1;
      6'd1:    nl_raw = nl2;
      6'd2:    nl_raw = nl3;
      6'd3:    nl_raw = nl4;
      default: nl_raw = nl5;
    endcase
    case (n_q)
      6'd1:    prev_raw = nl1;
      6'd2:    prev_raw = nl2;
      6'd3:    prev_raw = nl3;
      default: prev_raw = nl4;
    endcase
    nl_cur = (nl_raw == 6'd0) ? CW'(1) : CW'(nl_raw);
    if (n_q == 6'd0)
      fan_in = CW'(N_INPUTS);
    else
      fan_in = (prev_raw == 6'd0) ? CW'(1) : CW'(prev_raw);
    case (state_q)
      S_LOAD_B, S_LOAD_W: phase_len = nl_cur;
      S_MAC:              phase_len = CW'(MAC_CYCLES);
      S_ACT:              phase_len = CW'(AF_CYCLES);
      default:            phase_len = CW'(1);
    endcase
    phase_last = (c_q == phase_len - CW'(1));
    i_last     = (CW'(i_q) == fan_in - CW'(1));
  end

  always_comb begin
    state_d = state_q;
    c_d     = '0;
    n_d     = n_q;
    i_d     = i_q;
    case (state_q)
      S_IDLE: if (start) begin
        n_d     = '0;
        i_d     = '0;
        state_d = (layers_eff == 6'd0) ? S_DONE : S_LOAD_B;
      end
      S_LOAD_B, S_LOAD_W, S_MAC, S_ACT: begin
        if (phase_last) begin
          case (state_q)
            S_LOAD_B: state_d = S_LOAD_W;
            S_LOAD_W: state_d = S_MAC;
            S_MAC:    state_d = S_NEXT;
            default:  state_d = S_WR;
          endcase
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_NEXT: begin
        if (i_last) begin
          i_d     = '0;
          state_d = S_ADD_B;
        end else begin
          i_d     = i_q + 6'd1;
          state_d = S_LOAD_W;
        end
      end
      S_ADD_B: state_d = S_ACT;
      S_WR: begin
        n_d     = n_q + 6'd1;
        state_d = (n_q + 6'd1 == layers_eff) ? S_DONE : S_LOAD_B;
      end
      S_DONE: begin
`ifdef MCP_AUTO_RESTART_EN
        state_d = S_IDLE;
`else
        if (!start) state_d = S_IDLE;
`endif
        if (state_d == S_IDLE) n_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the present state; the first LOAD_W of a layer (i==0) precedes any MAC.
  always_comb begin
    ctrl_d              = '0;
    ctrl_d.weight_en    = (state_q == S_LOAD_W);
    ctrl_d.bias_en      = (state_q == S_LOAD_B) || (state_q == S_ADD_B);
    ctrl_d.bias_sign    = (state_q == S_ADD_B);
    ctrl_d.compute_en   = (state_q == S_MAC) || (state_q == S_NEXT) || (state_q == S_ADD_B) ||
                          (state_q == S_ACT) || (state_q == S_WR) ||
                          ((state_q == S_LOAD_W) && (i_q != 6'd0));
    ctrl_d.af_en        = (state_q == S_ACT);
    ctrl_d.out_shft_en  = (state_q == S_NEXT) && (n_q != 6'd0);
    ctrl_d.out_wr_en    = (state_q == S_WR);
    ctrl_d.output_sig   = (state_q != S_IDLE) && (state_q != S_DONE) && (n_q != 6'd0);
    ctrl_d.tot_complete = (state_q == S_DONE);
    ctrl_d.n            = n_q;
    ctrl_d.i            = i_q;
  end

  // NOTE: all state, counters and output flops use non-blocking assignments so every register
  // samples the pre-edge values; outputs are registered from the decoded present state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      c_q          <= '0;
      n_q          <= '0;
      i_q          <= '0;
      weight_en    <= 1'b0;
      bias_en      <= 1'b0;
      compute_en   <= 1'b0;
      af_en        <= 1'b0;
      out_shft_en  <= 1'b0;
      out_wr_en    <= 1'b0;
      output_sig   <= 1'b0;
      bias_sign    <= 1'b0;
      tot_complete <= 1'b0;
      n            <= '0;
      i            <= '0;
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      n_q          <= n_d;
      i_q          <= i_d;
      weight_en    <= ctrl_d.weight_en;
      bias_en      <= ctrl_d.bias_en;
      compute_en   <= ctrl_d.compute_en;
      af_en        <= ctrl_d.af_en;
      out_shft_en  <= ctrl_d.out_shft_en;
      out_wr_en    <= ctrl_d.out_wr_en;
      output_sig   <= ctrl_d.output_sig;
      bias_sign    <= ctrl_d.bias_sign;
      tot_complete <= ctrl_d.tot_complete;
      n            <= ctrl_d.n;
      i            <= ctrl_d.i;
    end
  end

endmodule

// File: tb/tb_master_control_path.sv
// Scoreboard bench for master_control_path: a layer-loop reference model queues the expected
// per-cycle control vector, and a negedge monitor pops and compares it against the DUT.
module tb_master_control_path;

  localparam int N_IN = 4;
  localparam int MACC = 2;
  localparam int AFC  = 2;

  typedef struct packed {
    logic       weight_en;
    logic       bias_en;
    logic       compute_en;
    logic       af_en;
    logic       out_shft_en;
    logic       out_wr_en;
    logic       output_sig;
    logic       bias_sign;
    logic       tot_complete;
    logic [5:0] n;
    logic [5:0] i;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] no_layers, nl1, nl2, nl3, nl4, nl5;
  logic       weight_en, bias_en, compute_en, af_en, out_shft_en, out_wr_en;
  logic       output_sig, bias_sign, tot_complete;
  logic [5:0] n, i;

  int   checks = 0;
  int   errors = 0;
  int   case_id = 0;
  int   sample_id = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  master_control_path #(.N_INPUTS(N_IN), .MAC_CYCLES(MACC), .AF_CYCLES(AFC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .no_layers(no_layers),
    .nl1(nl1), .nl2(nl2), .nl3(nl3), .nl4(nl4), .nl5(nl5),
    .weight_en(weight_en), .bias_en(bias_en), .compute_en(compute_en), .af_en(af_en),
    .out_shft_en(out_shft_en), .out_wr_en(out_wr_en), .output_sig(output_sig),
    .bias_sign(bias_sign), .tot_complete(tot_complete), .n(n), .i(i)
  );

  function automatic obs_t sample();
    obs_t s;
    s = '{weight_en, bias_en, compute_en, af_en, out_shft_en, out_wr_en,
          output_sig, bias_sign, tot_complete, n, i};
    return s;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the scoreboard holds an entry, compare the DUT against it.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("case%0d_s%0d", case_id, sample_id), sample(), e);
        sample_id++;
      end
    end
  end

  function automatic obs_t mk(input int layer, input int inp);
    obs_t v;
    v            = '0;
    v.n          = 6'(layer);
    v.i          = 6'(inp);
    v.output_sig = (layer != 0);
    return v;
  endfunction

  // Reference model: expected control vector per cycle, from the layer/input loop structure.
  task automatic build_trace(input int nlay, input int nls[5], input int hold, output int busy);
    obs_t v;
    int le, nl, fan;
    busy = 0;
    le   = (nlay > 5) ? 5 : nlay;
    exp_q.push_back('0);
    for (int l = 0; l < le; l++) begin
      nl  = (nls[l] == 0) ? 1 : nls[l];
      fan = (l == 0) ? N_IN : ((nls[l-1] == 0) ? 1 : nls[l-1]);
      v = mk(l, 0); v.bias_en = 1;
      repeat (nl) begin exp_q.push_back(v); busy++; end
      for (int k = 0; k < fan; k++) begin
        v = mk(l, k); v.weight_en = 1; v.compute_en = (k != 0);
        repeat (nl) begin exp_q.push_back(v); busy++; end
        v = mk(l, k); v.compute_en = 1;
        repeat (MACC) begin exp_q.push_back(v); busy++; end
        v.out_shft_en = (l != 0);
        exp_q.push_back(v); busy++;
      end
      v = mk(l, 0); v.compute_en = 1; v.bias_en = 1; v.bias_sign = 1;
      exp_q.push_back(v); busy++;
      v = mk(l, 0); v.compute_en = 1; v.af_en = 1;
      repeat (AFC) begin exp_q.push_back(v); busy++; end
      v = mk(l, 0); v.compute_en = 1; v.out_wr_en = 1;
      exp_q.push_back(v); busy++;
    end
    v = '0; v.tot_complete = 1; v.n = 6'(le);
    repeat (hold + 1) exp_q.push_back(v);
    exp_q.push_back('0);
  endtask

  task automatic run_case(input int nlay, input int na, input int nb, input int nc,
                          input int nd, input int ne, input int hold_in);
    int nls[5];
    int busy, hold;
    hold = hold_in;
`ifdef MCP_AUTO_RESTART_EN
    hold = 0;
`endif
    nls = '{na, nb, nc, nd, ne};
    @(negedge clk);
    case_id++;
    sample_id = 0;
    no_layers = 6'(nlay);
    nl1 = 6'(na); nl2 = 6'(nb); nl3 = 6'(nc); nl4 = 6'(nd); nl5 = 6'(ne);
    start = 1'b1;
    @(posedge clk);
    build_trace(nlay, nls, hold, busy);
    repeat (busy + hold + 1) @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL case%0d_drain actual=%0d_left required=0_left", case_id, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic reset_mid_act();
    int found;
    @(negedge clk);
    no_layers = 6'd1; nl1 = 6'd2;
    start = 1'b1;
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(negedge clk);
      if (af_en === 1'b1) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL act_timeout actual=no_af_en required=af_en_within_200");
    end
    #2 rst_n = 1'b0;
    start = 1'b0;
    #1 check("reset_mid_act", sample(), '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    no_layers = '0; nl1 = '0; nl2 = '0; nl3 = '0; nl4 = '0; nl5 = '0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", sample(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_case(1, 2, 0, 0, 0, 0, 0);   // single layer reference timing
    run_case(2, 3, 2, 0, 0, 0, 0);   // layer 1 fans in from layer 0 via output bank
    run_case(0, 1, 1, 1, 1, 1, 1);   // no layers: straight to DONE
    run_case(1, 0, 0, 0, 0, 0, 0);   // zero neurons treated as one
    run_case(7, 1, 2, 3, 2, 1, 0);   // clamped to five layers
    run_case(1, 2, 0, 0, 0, 0, 3);   // start held high in DONE
    reset_mid_act();
    run_case(1, 2, 0, 0, 0, 0, 0);   // full sequence after mid-run reset
    for (int r = 0; r < 12; r++)
      run_case(int'($urandom_range(0, 7)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 2)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
